aes_rcon_seq: RTL and testbench

//  Parametrised round-constant sequencer for AES key expansion, covering AES-128, AES-192 and AES-256.

---
 rtl/aes_pkg.sv | 54 +++++
 rtl/aes_rcon_step.sv | 39 +++
 rtl/aes_rcon_seq.sv | 124 ++++++++++++
 tb/tb_aes_rcon_seq.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared types and helpers for the AES round-constant sequencer.
package aes_pkg;

  localparam logic [1:0] MODE_128 = 2'd0;
  localparam logic [1:0] MODE_192 = 2'd1;
  localparam logic [1:0] MODE_256 = 2'd2;
  localparam logic [1:0] MODE_BAD = 2'd3;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } st_e;

  function automatic logic [3:0] nk_of(input logic [1:0] m);
    logic [3:0] r;
    unique case (m)
      MODE_192: r = 4'd6;
      MODE_256: r = 4'd8;
      default:  r = 4'd4;
    endcase
    return r;
  endfunction

  function automatic logic [5:0] total_of(input logic [1:0] m);
    logic [5:0] r;
    unique case (m)
      MODE_192: r = 6'd52;
      MODE_256: r = 6'd60;
      default:  r = 6'd44;
    endcase
    return r;
  endfunction

  // Rcon of the final word group, the start point of the reverse walk
  function automatic logic [7:0] last_rcon(input logic [1:0] m);
    logic [7:0] r;
    unique case (m)
      MODE_192: r = 8'h80;
      MODE_256: r = 8'h40;
      default:  r = 8'h36;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] ixtime(input logic [7:0] b);
    return b[0] ? (((b ^ 8'h1b) >> 1) | 8'h80) : (b >> 1);
  endfunction

endpackage

// File: rtl/aes_rcon_step.sv
// Combinational next Rcon / phase / index for one word step.
import aes_pkg::*;

module aes_rcon_step #(
  parameter int IDX_W = 6
) (
  input  logic [7:0]       rcon,
  input  logic [2:0]       p,
  input  logic [IDX_W-1:0] idx,
  input  logic [3:0]       nk,
  input  logic             dir,
  output logic [7:0]       rcon_nx,
  output logic [2:0]       p_nx,
  output logic [IDX_W-1:0] idx_nx
);

  logic wrap;

  always_comb begin
    wrap    = 1'b0;
    rcon_nx = rcon;
    p_nx    = p;
    idx_nx  = idx;
    if (dir) begin
      wrap   = (p == 3'd0);
      p_nx   = wrap ? 3'(nk - 4'd1) : p - 3'd1;
      idx_nx = idx - IDX_W'(1);
      if (wrap)
        rcon_nx = ixtime(rcon);
    end else begin
      wrap   = ({1'b0, p} == nk - 4'd1);
      p_nx   = wrap ? 3'd0 : p + 3'd1;
      idx_nx = idx + IDX_W'(1);
      if (wrap)
        rcon_nx = xtime(rcon);
    end
  end

endmodule

// File: rtl/aes_rcon_seq.sv
// AES key-expansion round-constant sequencer (AES-128/192/256).
// Optional reverse walk for the decryption schedule: AES_RCON_INV_EN.
import aes_pkg::*;

module aes_rcon_seq #(
  parameter int WORD_W    = 32,
  parameter int RCON_LANE = 3,
  parameter int IDX_W     = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              kld,
  input  logic [1:0]        mode,
`ifdef AES_RCON_INV_EN
  input  logic              dir,
`endif
  input  logic              adv,
  output logic [WORD_W-1:0] rcon_o,
  output logic [IDX_W-1:0]  widx_o,
  output logic              rot_o,
  output logic              sub_o,
  output logic              valid_o,
  output logic              done_o,
  output logic              err_o
);

  st_e        st;
  logic [1:0] mode_q;
  logic       dir_q;
  logic       dir_in;
  logic [2:0] p_q;
  logic [7:0] rcon_q;

  logic [3:0]       nk_q;
  logic [5:0]       tot_q;
  logic [7:0]       rcon_nx;
  logic [2:0]       p_nx;
  logic [IDX_W-1:0] idx_nx;
  logic             at_end;

`ifdef AES_RCON_INV_EN
  assign dir_in = dir;
`else
  assign dir_in = 1'b0;
`endif

  assign nk_q  = nk_of(mode_q);
  assign tot_q = total_of(mode_q);

  assign at_end = dir_q ? (widx_o == IDX_W'(nk_q))
                        : (widx_o == IDX_W'(tot_q - 6'd1));

  assign rcon_o = WORD_W'(rcon_q) << (8 * RCON_LANE);

  aes_rcon_step #(
    .IDX_W(IDX_W)
  ) u_step (
    .rcon   (rcon_q),
    .p      (p_q),
    .idx    (widx_o),
    .nk     (nk_q),
    .dir    (dir_q),
    .rcon_nx(rcon_nx),
    .p_nx   (p_nx),
    .idx_nx (idx_nx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      st      <= IDLE;
      mode_q  <= MODE_128;
      dir_q   <= 1'b0;
      p_q     <= 3'd0;
      rcon_q  <= 8'h00;
      widx_o  <= '0;
      rot_o   <= 1'b0;
      sub_o   <= 1'b0;
      valid_o <= 1'b0;
      done_o  <= 1'b0;
      err_o   <= 1'b0;
    end else if (kld) begin
      rot_o  <= 1'b0;
      sub_o  <= 1'b0;
      done_o <= 1'b0;
      if (mode == MODE_BAD) begin
        st      <= IDLE;
        valid_o <= 1'b0;
        err_o   <= 1'b1;
      end else begin
        st      <= RUN;
        mode_q  <= mode;
        dir_q   <= dir_in;
        valid_o <= 1'b1;
        err_o   <= 1'b0;
        // every schedule's final word sits at phase 3
        if (dir_in) begin
          p_q    <= 3'd3;
          rcon_q <= last_rcon(mode);
          widx_o <= IDX_W'(total_of(mode) - 6'd1);
        end else begin
          p_q    <= 3'd0;
          rcon_q <= 8'h01;
          widx_o <= IDX_W'(nk_of(mode));
          rot_o  <= 1'b1;
        end
      end
    end else if (adv && st == RUN) begin
      if (at_end) begin
        st      <= DONE;
        valid_o <= 1'b0;
        done_o  <= 1'b1;
        rot_o   <= 1'b0;
        sub_o   <= 1'b0;
      end else begin
        p_q    <= p_nx;
        rcon_q <= rcon_nx;
        widx_o <= idx_nx;
        rot_o  <= (p_nx == 3'd0);
        sub_o  <= (mode_q == MODE_256) && (p_nx == 3'd4);
      end
    end
  end

endmodule

// File: tb/tb_aes_rcon_seq.sv
// Directed self-checking bench for aes_rcon_seq.
`timescale 1ns/1ps

module tb_aes_rcon_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        kld;
  logic [1:0]  mode;
  logic        dir;
  logic        adv;
  logic [31:0] rcon_o;
  logic [5:0]  widx_o;
  logic        rot_o, sub_o, valid_o, done_o, err_o;

  int total = 0;
  int bad   = 0;

  logic [7:0] rc [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                          8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  always #5 clk = ~clk;

  aes_rcon_seq dut (
    .clk    (clk),
    .rst    (rst),
    .kld    (kld),
    .mode   (mode),
`ifdef AES_RCON_INV_EN
    .dir    (dir),
`endif
    .adv    (adv),
    .rcon_o (rcon_o),
    .widx_o (widx_o),
    .rot_o  (rot_o),
    .sub_o  (sub_o),
    .valid_o(valid_o),
    .done_o (done_o),
    .err_o  (err_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; kld = 1'b0; mode = 2'd0; dir = 1'b0; adv = 1'b0;
    tick();
    tick();
    chk("rst_rcon", rcon_o, 32'h0);
    chk("rst_widx", 32'(widx_o), 32'd0);
    chk("rst_flags", {27'd0, rot_o, sub_o, valid_o, done_o, err_o}, 32'd0);

    // AES-128, adv held high throughout
    rst = 1'b0; kld = 1'b1; mode = 2'd0; adv = 1'b1;
    tick();
    kld = 1'b0;
    chk("m0_start_widx", 32'(widx_o), 32'd4);
    chk("m0_start_rcon", rcon_o, 32'h01000000);
    chk("m0_start_rv", {30'd0, rot_o, valid_o}, 32'd3);
    for (int i = 5; i <= 43; i++) begin
      tick();
      chk("m0_widx", 32'(widx_o), 32'(i));
      chk("m0_rcon", rcon_o, {rc[i/4 - 1], 24'h0});
      chk("m0_rot", 32'(rot_o), 32'((i % 4) == 0));
      chk("m0_done_early", 32'(done_o), 32'd0);
    end
    chk("m0_i36", {rc[8], 24'h0}, rcon_o == 32'h36000000 ? 32'h1b000000 : 32'h0);
    tick();
    chk("m0_done40", {30'd0, done_o, valid_o}, 32'd2);
    chk("m0_hold_widx", 32'(widx_o), 32'd43);
    chk("m0_hold_rcon", rcon_o, 32'h36000000);
    tick();
    chk("m0_done_adv_ign", 32'(widx_o), 32'd43);

    // AES-192
    kld = 1'b1; mode = 2'd1;
    tick();
    kld = 1'b0;
    chk("m1_start_widx", 32'(widx_o), 32'd6);
    for (int i = 7; i <= 51; i++) begin
      tick();
      chk("m1_widx", 32'(widx_o), 32'(i));
      chk("m1_rot", 32'(rot_o), 32'((i % 6) == 0));
      chk("m1_sub", 32'(sub_o), 32'd0);
      chk("m1_rcon", rcon_o, {rc[i/6 - 1], 24'h0});
    end
    chk("m1_last_rcon", rcon_o, 32'h80000000);
    tick();
    chk("m1_done", 32'(done_o), 32'd1);

    // AES-256
    kld = 1'b1; mode = 2'd2;
    tick();
    kld = 1'b0;
    chk("m2_start_widx", 32'(widx_o), 32'd8);
    chk("m2_start_sub", 32'(sub_o), 32'd0);
    for (int i = 9; i <= 59; i++) begin
      tick();
      chk("m2_widx", 32'(widx_o), 32'(i));
      chk("m2_sub", 32'(sub_o), 32'((i % 8) == 4));
      chk("m2_rot", 32'(rot_o), 32'((i % 8) == 0));
      chk("m2_rcon", rcon_o, {rc[i/8 - 1], 24'h0});
    end
    chk("m2_last_rcon", rcon_o, 32'h40000000);
    chk("m2_not_done51", 32'(done_o), 32'd0);
    tick();
    chk("m2_done52", 32'(done_o), 32'd1);

    // restart mid-run, kld beats adv
    kld = 1'b1; mode = 2'd0; adv = 1'b0;
    tick();
    kld = 1'b0; adv = 1'b1;
    for (int k = 0; k < 7; k++) tick();
    chk("rs_pre_widx", 32'(widx_o), 32'd11);
    chk("rs_pre_rcon", rcon_o, 32'h02000000);
    kld = 1'b1; mode = 2'd2;
    tick();
    kld = 1'b0; adv = 1'b0;
    chk("rs_widx", 32'(widx_o), 32'd8);
    chk("rs_rcon", rcon_o, 32'h01000000);
    chk("rs_rot", 32'(rot_o), 32'd1);

    // illegal mode
    kld = 1'b1; mode = 2'd3;
    tick();
    kld = 1'b0; adv = 1'b1;
    chk("bad_err", 32'(err_o), 32'd1);
    chk("bad_valid", 32'(valid_o), 32'd0);
    tick();
    chk("bad_adv_widx", 32'(widx_o), 32'd8);
    chk("bad_adv_flags", {29'd0, valid_o, done_o, err_o}, 32'd1);

    // reset during RUN
    kld = 1'b1; mode = 2'd0;
    tick();
    kld = 1'b0;
    chk("err_clear", 32'(err_o), 32'd0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; adv = 1'b0;
    chk("rrun_rcon", rcon_o, 32'h0);
    chk("rrun_widx", 32'(widx_o), 32'd0);
    chk("rrun_flags", {27'd0, rot_o, sub_o, valid_o, done_o, err_o}, 32'd0);

`ifdef AES_RCON_INV_EN
    kld = 1'b1; mode = 2'd0; dir = 1'b1;
    tick();
    kld = 1'b0; dir = 1'b0; adv = 1'b1;
    chk("inv_widx", 32'(widx_o), 32'd43);
    chk("inv_rcon", rcon_o, 32'h36000000);
    for (int k = 0; k < 4; k++) tick();
    chk("inv4_widx", 32'(widx_o), 32'd39);
    chk("inv4_rcon", rcon_o, 32'h1b000000);
    chk("inv4_rot", 32'(rot_o), 32'd0);
    for (int k = 4; k < 39; k++) tick();
    chk("inv39_widx", 32'(widx_o), 32'd4);
    chk("inv39_rcon", rcon_o, 32'h01000000);
    chk("inv39_done", 32'(done_o), 32'd0);
    tick();
    chk("inv40_done", 32'(done_o), 32'd1);
    adv = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
